serv_immdec: RTL and testbench

// - Immediate decoder/serializer directly upstream of the control (PC) stage of the bit-serial core.
// - Captures a fetched instruction word, extracts and sign-extends its immediate (I/S/B/U/J), then

---
 rtl/serv_immdec_pkg.sv | 29 ++
 rtl/serv_imm_extract.sv | 66 ++++++
 rtl/serv_immdec.sv | 95 +++++++++
 tb/tb_serv_immdec.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serv_immdec_pkg.sv
// Shared types and opcode constants for the serial immediate decoder.
// Optional zimm support is enabled by defining SERV_IMMDEC_ZIMM_EN.
package serv_immdec_pkg;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_type_e;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_OPIMM  = 5'b00100;
    localparam logic [4:0] OP_SYSTEM = 5'b11100;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;

endpackage

// File: rtl/serv_imm_extract.sv
// Combinational immediate extraction and sign extension from an instruction word.
// SERV_IMMDEC_ZIMM_EN selects zero-extended zimm for CSR*I instructions.
module serv_imm_extract
    import serv_immdec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     rdt,
    output logic [XLEN-1:0] imm,
    output imm_type_e       imm_type
);

    logic [4:0]  op;
    logic [31:0] imm32;
    logic        unused_bits;

    assign op          = rdt[6:2];
    assign unused_bits = ^{rdt[1:0], rdt[14:12]};

    always_comb begin
        imm32    = '0;
        imm_type = IMM_NONE;
        unique case (1'b1)
            (op == OP_LUI) || (op == OP_AUIPC): begin
                imm32    = {rdt[31:12], 12'h000};
                imm_type = IMM_U;
            end
            (op == OP_JAL): begin
                imm32    = {{12{rdt[31]}}, rdt[19:12],
                            rdt[20], rdt[30:21], 1'b0};
                imm_type = IMM_J;
            end
            (op == OP_JALR) || (op == OP_LOAD) ||
            (op == OP_OPIMM): begin
                imm32    = {{20{rdt[31]}}, rdt[31:20]};
                imm_type = IMM_I;
            end
            (op == OP_SYSTEM): begin
                imm32    = {{20{rdt[31]}}, rdt[31:20]};
                imm_type = IMM_I;
`ifdef SERV_IMMDEC_ZIMM_EN
                if (rdt[14]) begin
                    imm32 = {27'd0, rdt[19:15]};
                end
`endif
            end
            (op == OP_STORE): begin
                imm32    = {{20{rdt[31]}}, rdt[31:25], rdt[11:7]};
                imm_type = IMM_S;
            end
            (op == OP_BRANCH): begin
                imm32    = {{20{rdt[31]}}, rdt[7], rdt[30:25],
                            rdt[11:8], 1'b0};
                imm_type = IMM_B;
            end
            default: begin
                imm32    = '0;
                imm_type = IMM_NONE;
            end
        endcase
    end

    // Extend the 32-bit immediate to XLEN by replicating its sign bit.
    assign imm = {{(XLEN-31){imm32[31]}}, imm32[30:0]};

endmodule

// File: rtl/serv_immdec.sv
// Immediate decoder/serializer: loads a formatted immediate and shifts it out LSB-first.
// Define SERV_IMMDEC_ZIMM_EN to load zimm for CSRRWI/CSRRSI/CSRRCI.
module serv_immdec
    import serv_immdec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic        i_wb_en,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_cnt_en,
    output logic        o_imm,
    output logic        o_utype,
    output logic        o_busy,
    output logic        o_done
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_MAX = CW'(XLEN - 1);

    state_e          state;
    state_e          state_n;
    logic [XLEN-1:0] sreg;
    logic [CW-1:0]   cnt;
    imm_type_e       imm_type;
    logic            done;

    logic [XLEN-1:0] ext_imm;
    imm_type_e       ext_type;
    logic            load;
    logic            step;
    logic            last;

    serv_imm_extract #(
        .XLEN     (XLEN)
    ) u_extract (
        .rdt      (i_wb_rdt),
        .imm      (ext_imm),
        .imm_type (ext_type)
    );

    always_comb begin
        state_n = state;
        load    = 1'b0;
        step    = 1'b0;
        last    = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_wb_en) begin
                    load    = 1'b1;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (i_cnt_en) begin
                    step = 1'b1;
                    if (cnt == CNT_MAX) begin
                        last    = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            sreg     <= '0;
            cnt      <= '0;
            imm_type <= IMM_NONE;
            done     <= 1'b0;
        end else begin
            state <= state_n;
            done  <= last;
            if (load) begin
                sreg     <= ext_imm;
                cnt      <= '0;
                imm_type <= ext_type;
            end else if (step) begin
                // Arithmetic shift keeps the sign bit in place once consumed.
                sreg <= {sreg[XLEN-1], sreg[XLEN-1:1]};
                cnt  <= last ? '0 : cnt + 1'b1;
            end
        end
    end

    assign o_imm   = sreg[0];
    assign o_utype = (imm_type == IMM_U);
    assign o_busy  = (state == SHIFT);
    assign o_done  = done;

endmodule

// File: tb/tb_serv_immdec.sv
// Self-checking bench for serv_immdec: scoreboard of expected serial bits.
// Expected zimm behaviour follows SERV_IMMDEC_ZIMM_EN.
module tb_serv_immdec;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic        i_wb_en;
    logic [31:0] i_wb_rdt;
    logic        i_cnt_en;
    logic        o_imm;
    logic        o_utype;
    logic        o_busy;
    logic        o_done;

    int   n_checks = 0;
    int   n_fail   = 0;
    bit   exp_q[$];
    logic exp_utype;

    always #5 clk = ~clk;

    serv_immdec dut (
        .clk      (clk),
        .i_rst_n  (i_rst_n),
        .i_wb_en  (i_wb_en),
        .i_wb_rdt (i_wb_rdt),
        .i_cnt_en (i_cnt_en),
        .o_imm    (o_imm),
        .o_utype  (o_utype),
        .o_busy   (o_busy),
        .o_done   (o_done)
    );

    function automatic logic [31:0] ref_imm(input logic [31:0] w);
        logic [31:0] i_imm;
        i_imm = {{20{w[31]}}, w[31:20]};
        case (w[6:2])
            5'b01101, 5'b00101: return {w[31:12], 12'h000};
            5'b11011: return {{12{w[31]}}, w[19:12], w[20],
                              w[30:21], 1'b0};
            5'b11001, 5'b00000, 5'b00100: return i_imm;
            5'b11100: begin
`ifdef SERV_IMMDEC_ZIMM_EN
                if (w[14]) return {27'd0, w[19:15]};
`endif
                return i_imm;
            end
            5'b01000: return {{20{w[31]}}, w[31:25], w[11:7]};
            5'b11000: return {{20{w[31]}}, w[7], w[30:25],
                              w[11:8], 1'b0};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic ref_utype(input logic [31:0] w);
        return (w[6:2] == 5'b01101) || (w[6:2] == 5'b00101);
    endfunction

    // Drive at a negedge while the DUT is idle; queue the expected bits.
    task automatic load_instr(input logic [31:0] w,
                              input logic [31:0] exp_val);
        exp_q.delete();
        for (int i = 0; i < 32; i++) exp_q.push_back(exp_val[i]);
        exp_utype = ref_utype(w);
        i_wb_en   = 1'b1;
        i_wb_rdt  = w;
        @(negedge clk);
        i_wb_en = 1'b0;
        n_checks++;
        if (o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL load_busy: got %b want 1", o_busy);
        end
        n_checks++;
        if (o_utype !== exp_utype) begin
            n_fail++;
            $display("FAIL load_utype: got %b want %b",
                     o_utype, exp_utype);
        end
    endtask

    task automatic shift_steps(input int n, input bit toggle);
        int steps = 0;
        int cyc   = 0;
        bit ph    = 1'b0;
        bit eb;
        while (steps < n && cyc < 300) begin
            i_cnt_en = toggle ? ph : 1'b1;
            ph = ~ph;
            if (i_cnt_en) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL imm_bit: got %b want none", o_imm);
                end else begin
                    eb = exp_q.pop_front();
                    if (o_imm !== eb) begin
                        n_fail++;
                        $display("FAIL imm_bit %0d: got %b want %b",
                                 32 - exp_q.size() - 1, o_imm, eb);
                    end
                end
                steps++;
            end
            @(negedge clk);
            cyc++;
        end
        i_cnt_en = 1'b0;
        if (steps < n) begin
            n_checks++;
            n_fail++;
            $display("FAIL shift_timeout: got %0d want %0d", steps, n);
        end
    endtask

    task automatic check_done(input bit then_idle);
        n_checks++;
        if (o_done !== 1'b1 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse: got done=%b busy=%b want 1 0",
                     o_done, o_busy);
        end
        n_checks++;
        if (o_utype !== exp_utype) begin
            n_fail++;
            $display("FAIL utype_hold: got %b want %b",
                     o_utype, exp_utype);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_left: got %0d want 0", exp_q.size());
        end
        if (then_idle) begin
            @(negedge clk);
            n_checks++;
            if (o_done !== 1'b0) begin
                n_fail++;
                $display("FAIL done_single: got %b want 0", o_done);
            end
        end
    endtask

    task automatic run_instr(input logic [31:0] w, input bit toggle);
        load_instr(w, ref_imm(w));
        shift_steps(32, toggle);
        check_done(1'b1);
    endtask

    task automatic test_reset;
        i_rst_n  = 1'b0;
        i_wb_en  = 1'b0;
        i_wb_rdt = 32'h0;
        i_cnt_en = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({o_imm, o_utype, o_busy, o_done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outs: got %b want 0000",
                     {o_imm, o_utype, o_busy, o_done});
        end
        i_rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got %b want 0", o_busy);
        end
    endtask

    task automatic test_lui;
        n_checks++;
        if (ref_imm(32'h123450B7) !== 32'h12345000) begin
            n_fail++;
            $display("FAIL lui_model: got %h want 12345000",
                     ref_imm(32'h123450B7));
        end
        load_instr(32'h123450B7, 32'h12345000);
        shift_steps(32, 1'b0);
        check_done(1'b1);
    endtask

    task automatic test_i_j;
        load_instr(32'hFFF00093, 32'hFFFFFFFF);
        shift_steps(32, 1'b0);
        check_done(1'b1);
        load_instr(32'hFFDFF0EF, 32'hFFFFFFFC);
        shift_steps(32, 1'b0);
        check_done(1'b1);
    endtask

    task automatic test_branch_toggle;
        run_instr(32'hFE000EE3, 1'b1);
    endtask

    task automatic test_store_other;
        load_instr(32'hFE512C23, 32'hFFFFFFF8);
        shift_steps(32, 1'b0);
        check_done(1'b1);
        load_instr(32'h0000000B, 32'h00000000);
        shift_steps(32, 1'b0);
        check_done(1'b1);
    endtask

    task automatic test_back_to_back;
        load_instr(32'h00A00513, 32'h0000000A);
        shift_steps(10, 1'b0);
        i_wb_en  = 1'b1;
        i_wb_rdt = 32'h123450B7;
        @(negedge clk);
        i_wb_en = 1'b0;
        n_checks++;
        if (o_busy !== 1'b1 || o_utype !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_reload: got busy=%b utype=%b want 1 0",
                     o_busy, o_utype);
        end
        shift_steps(22, 1'b0);
        check_done(1'b0);
        load_instr(32'h123450B7, 32'h12345000);
        shift_steps(32, 1'b0);
        check_done(1'b1);
    endtask

    task automatic test_reset_mid;
        load_instr(32'h123450B7, 32'h12345000);
        shift_steps(17, 1'b0);
        i_rst_n  = 1'b0;
        i_cnt_en = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({o_imm, o_utype, o_busy, o_done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_reset: got %b want 0000",
                     {o_imm, o_utype, o_busy, o_done});
        end
        i_rst_n = 1'b1;
        exp_q.delete();
        repeat (20) begin
            @(negedge clk);
            n_checks++;
            if (o_done !== 1'b0 || o_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset: got done=%b busy=%b want 0 0",
                         o_done, o_busy);
            end
        end
        i_cnt_en = 1'b0;
    endtask

    task automatic test_csr;
        logic [31:0] exp_val;
`ifdef SERV_IMMDEC_ZIMM_EN
        exp_val = 32'h00000015;
`else
        exp_val = 32'h00000340;
`endif
        load_instr(32'h340AD0F3, exp_val);
        shift_steps(32, 1'b0);
        check_done(1'b1);
    endtask

    initial begin
        exp_utype = 1'b0;
        test_reset();
        test_lui();
        test_i_j();
        test_branch_toggle();
        test_store_other();
        test_back_to_back();
        test_reset_mid();
        test_csr();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
